// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between an operand source and the
// bit-serial adder. The source drives start and the operands. The adder
// returns the registered result together with busy/done status.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic [WIDTH-1:0] Sum;
    logic             C_out;
    logic             Ovf;
    logic             busy;
    logic             done;

    // Operand source side: issues requests and consumes results
    modport master (
        output start, A, B, C_in,
        input  Sum, C_out, Ovf, busy, done
    );

    // Adder side: accepts requests and produces results
    modport slave (
        input  start, A, B, C_in,
        output Sum, C_out, Ovf, busy, done
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. It feeds one operand bit pair per clock, LSB
// first, through a single 1-bit FullAdder cell. The carry is kept in a
// flip-flop between bits, and the sum bits are collected in a shift register.
// Results are registered and change only when an addition completes or when
// the block is reset.

// Combinational 1-bit full adder cell
module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic cIn_i,
    output logic s_o,
    output logic cOut_o
);
    assign s_o    = a_i ^ b_i ^ cIn_i;
    assign cOut_o = (a_i & b_i) | (cIn_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_ctrl_if.slave bus
);
    // The counter only needs to reach WIDTH-1.
    localparam int CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT state_q, state_d;

    // Operand shift registers. Bit 0 always holds the pair being added.
    logic [WIDTH-1:0] aSr_q, aSr_d;
    logic [WIDTH-1:0] bSr_q, bSr_d;

    // Only WIDTH-1 sum bits need storage. The MSB comes straight from the
    // cell on the last edge.
    logic [WIDTH-2:0] sSr_q, sSr_d;

    logic             carry_q, carry_d;
    logic             cMsb_q, cMsb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cOut_q, cOut_d;
    logic             ovf_q, ovf_d;

    logic             faS;
    logic             faCo;
    logic             inShift;
    logic             lastBit;
    logic             msbCarryBit;
    logic             busyComb;
    logic             doneComb;

    FullAdder faCell (
        .a_i    (aSr_q[0]),
        .b_i    (bSr_q[0]),
        .cIn_i  (carry_q),
        .s_o    (faS),
        .cOut_o (faCo)
    );

    assign inShift     = (state_q == SHIFT);
    assign lastBit     = inShift && (cnt_q == CntW'(WIDTH - 1));
    assign msbCarryBit = inShift && (cnt_q == CntW'(WIDTH - 2));

    // Control state register. Reset drops any operation in flight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is honoured only in IDLE, and DONE always lasts
    // one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (lastBit)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are a pure decode of the current state.
    always_comb begin
        busyComb = 1'b0;
        doneComb = 1'b0;
        case (state_q)
            SHIFT:   busyComb = 1'b1;
            DONE:    doneComb = 1'b1;
            default: begin
                busyComb = 1'b0;
                doneComb = 1'b0;
            end
        endcase
    end

    // Datapath next values. Operands are latched on an accepted start. Each
    // SHIFT edge consumes one bit pair, and the result registers load only
    // on the final bit.
    always_comb begin
        aSr_d   = aSr_q;
        bSr_d   = bSr_q;
        sSr_d   = sSr_q;
        carry_d = carry_q;
        cMsb_d  = cMsb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cOut_d  = cOut_q;
        ovf_d   = ovf_q;

        if (state_q == IDLE && bus.start) begin
            aSr_d   = bus.A;
            bSr_d   = bus.B;
            carry_d = bus.C_in;
            cnt_d   = '0;
        end else if (inShift) begin
            aSr_d   = aSr_q >> 1;
            bSr_d   = bSr_q >> 1;
            sSr_d   = (sSr_q >> 1) | ((WIDTH - 1)'(faS) << (WIDTH - 2));
            carry_d = faCo;
            cnt_d   = cnt_q + CntW'(1);
            if (msbCarryBit) begin
                cMsb_d = faCo;
            end
            if (lastBit) begin
                sum_d  = {faS, sSr_q};
                cOut_d = faCo;
                ovf_d  = faCo ^ cMsb_q;
            end
        end
    end

    // Datapath registers. Everything clears on reset, so an aborted addition
    // leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSr_q   <= '0;
            bSr_q   <= '0;
            sSr_q   <= '0;
            carry_q <= 1'b0;
            cMsb_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cOut_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            aSr_q   <= aSr_d;
            bSr_q   <= bSr_d;
            sSr_q   <= sSr_d;
            carry_q <= carry_d;
            cMsb_q  <= cMsb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cOut_q  <= cOut_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Sum   = sum_q;
    assign bus.C_out = cOut_q;
    assign bus.Ovf   = ovf_q;
    assign bus.busy  = busyComb;
    assign bus.done  = doneComb;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for the bit-serial adder. Expected results come from
// plain integer arithmetic on A, B and C_in, with the signed operand range
// used to decide overflow.
module tb_serial_adder_ctrl;
    localparam int W    = 4;
    localparam int MaxS = 2 ** (W - 1) - 1;
    localparam int MinS = -(2 ** (W - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int testCount = 0;
    int failCount = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    // Single comparison point: every check is counted here
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int toSigned(input int v);
        return (v >= 2 ** (W - 1)) ? v - 2 ** W : v;
    endfunction

    // Compare registered results against the arithmetic reference
    task automatic checkResult(input string tag, input int a, input int b, input int cin);
        int total;
        int sTotal;
        total  = a + b + cin;
        sTotal = toSigned(a) + toSigned(b) + cin;
        checkOutput({tag, "_sum"},  int'(bus.Sum),   total % (2 ** W));
        checkOutput({tag, "_cout"}, int'(bus.C_out), total / (2 ** W));
        checkOutput({tag, "_ovf"},  int'(bus.Ovf),   (sTotal > MaxS || sTotal < MinS) ? 1 : 0);
    endtask

    // Present operands at a falling edge and pulse start for one cycle
    task automatic applyStimulus(input int a, input int b, input int cin);
        @(negedge clk);
        bus.A     = W'(a);
        bus.B     = W'(b);
        bus.C_in  = 1'(cin);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // One full addition. When noise is set, the inputs (start included) are
    // scrambled while the adder is busy.
    task automatic runOp(input int a, input int b, input int cin, input string tag, input bit noise);
        int cycles;
        int busyCycles;
        applyStimulus(a, b, cin);
        cycles     = 0;
        busyCycles = 0;
        while (bus.done !== 1'b1 && cycles < 30) begin
            if (bus.busy === 1'b1) busyCycles++;
            if (noise) begin
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
                bus.C_in  = 1'($urandom);
                bus.start = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput({tag, "_latency"}, cycles, W);
        checkOutput({tag, "_busycycles"}, busyCycles, W);
        checkResult(tag, a, b, cin);
    endtask

    initial begin
        int cycles;
        int doneCount;
        int busyCount;
        int a;
        int b;
        int cin;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C_in  = 1'b0;

        // Reset must act immediately, without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_sum",  int'(bus.Sum),   0);
        checkOutput("rst_cout", int'(bus.C_out), 0);
        checkOutput("rst_ovf",  int'(bus.Ovf),   0);
        checkOutput("rst_busy", int'(bus.busy),  0);
        checkOutput("rst_done", int'(bus.done),  0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow, then carry wrap cases
        runOp(3, 5, 0, "ovf", 1'b0);
        runOp(15, 1, 0, "wrap1", 1'b0);
        runOp(15, 15, 1, "wrap2", 1'b0);

        // Asynchronous reset mid-cycle, with a nonzero result held
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_sum",  int'(bus.Sum),   0);
        checkOutput("midrst_cout", int'(bus.C_out), 0);
        checkOutput("midrst_ovf",  int'(bus.Ovf),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // start during SHIFT and during DONE is ignored
        applyStimulus(2, 2, 0);
        bus.A     = W'(7);
        bus.B     = W'(7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("ign_done_seen", int'(bus.done), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ign_sum", int'(bus.Sum), 4);
        doneCount = 0;
        busyCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
            if (bus.busy === 1'b1) busyCount++;
        end
        checkOutput("ign_extra_done", doneCount, 0);
        checkOutput("ign_extra_busy", busyCount, 0);
        checkOutput("ign_sum_hold", int'(bus.Sum), 4);

        // Reset during SHIFT aborts with no done pulse
        applyStimulus(9, 9, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_sum",  int'(bus.Sum),   0);
        checkOutput("abort_cout", int'(bus.C_out), 0);
        checkOutput("abort_busy", int'(bus.busy),  0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("abort_nodone", doneCount, 0);
        checkOutput("abort_idle_busy", int'(bus.busy), 0);
        runOp(9, 9, 0, "after_abort", 1'b0);

        // Exhaustive sweep with start held high; done must recur every W+2 cycles.
        @(negedge clk);
        bus.A     = W'(0);
        bus.B     = W'(0);
        bus.C_in  = 1'b0;
        bus.start = 1'b1;
        cycles = 0;
        for (int i = 0; i < 512; i++) begin
            while (bus.done !== 1'b1 && cycles < 30) begin
                @(negedge clk);
                cycles++;
            end
            a   = i % 16;
            b   = (i / 16) % 16;
            cin = i / 256;
            checkResult("exh", a, b, cin);
            if (i > 0) checkOutput("exh_spacing", cycles, W + 2);
            if (i < 511) begin
                bus.A    = W'((i + 1) % 16);
                bus.B    = W'(((i + 1) / 16) % 16);
                bus.C_in = 1'((i + 1) / 256);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles = 1;
        end

        // Random operands with inputs scrambled mid-operation
        repeat (40) begin
            runOp(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)), "rnd", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
